// File: rtl/reflet_boot_rom_pkg.sv
// Shared types and constants for the Reflet bootloader ROM sequencer/arbiter.
package reflet_boot_rom_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam logic [15:0] DEF_ROM_BASE = 16'h7E00;
    localparam int unsigned DEF_ROM_SIZE = 512;

    localparam int unsigned BUS_AW = 16;
    localparam int unsigned ROM_AW = 15;

    // True when addr falls inside the aligned window selected by mask.
    function automatic logic in_window(input logic [BUS_AW-1:0] addr,
                                       input logic [BUS_AW-1:0] base,
                                       input logic [BUS_AW-1:0] mask);
        return ((addr ^ base) & mask) == '0;
    endfunction

endpackage

// File: rtl/reflet_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last requester served.
module reflet_rr_arb2
    import reflet_boot_rom_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = '0;
        if (enable) begin
            if (req == 2'b11) begin
                if (last == REQ_CPU)
                    gnt[REQ_DBG] = 1'b1;
                else
                    gnt[REQ_CPU] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    // Resetting to "CPU served last" lets the debugger win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last <= REQ_CPU;
        else if (gnt[REQ_CPU])
            last <= REQ_CPU;
        else if (gnt[REQ_DBG])
            last <= REQ_DBG;
    end

endmodule

// File: rtl/reflet_boot_rom_ctrl.sv
// Bootloader ROM sequencer: shares the ROM's synchronous read port between the
// CPU and debug ports and closes the CPU's ROM window once boot has exited.
module reflet_boot_rom_ctrl
    import reflet_boot_rom_pkg::*;
#(
    parameter logic [15:0] ROM_BASE = DEF_ROM_BASE,
    parameter int unsigned ROM_SIZE = DEF_ROM_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    input  logic        dbg_req,
    input  logic [15:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [7:0]  dbg_rdata,
    input  logic        boot_exit,
    output logic        boot_active,
    output logic [14:0] rom_addr,
    output logic        rom_enable,
    input  logic [7:0]  rom_data
);

    localparam logic [BUS_AW-1:0] WIN_MASK = ~BUS_AW'(ROM_SIZE - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        arb_en;
    logic        capture;
    logic        gnt_any;
    logic        req_id;
    logic        hit_q;
    logic [15:0] sel_addr;
    logic        sel_hit;

    assign req     = {dbg_req, cpu_req};
    assign cpu_gnt = gnt[REQ_CPU];
    assign dbg_gnt = gnt[REQ_DBG];
    assign gnt_any = |gnt;

    reflet_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (arb_en),
        .req    (req),
        .gnt    (gnt)
    );

    assign sel_addr = gnt[REQ_DBG] ? dbg_addr : cpu_addr;
    assign sel_hit  = in_window(sel_addr, ROM_BASE, WIN_MASK)
                      && (gnt[REQ_DBG] || boot_active);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_any) state_next = ADDR;
            ADDR:    state_next = DATA;
            DATA:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grants are masked during reset so both gnt outputs read 0 while it is held.
    always_comb begin
        arb_en  = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE:    arb_en  = ~reset;
            DATA:    capture = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_id      <= REQ_CPU;
            hit_q       <= 1'b0;
            rom_addr    <= '0;
            rom_enable  <= 1'b0;
            cpu_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
            dbg_rvalid  <= 1'b0;
            dbg_rdata   <= '0;
            boot_active <= 1'b1;
        end else begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            if (boot_exit)
                boot_active <= 1'b0;
            if (gnt_any) begin
                req_id     <= gnt[REQ_DBG];
                rom_addr   <= sel_addr[ROM_AW-1:0];
                hit_q      <= sel_hit;
                rom_enable <= sel_hit;
            end else if (capture) begin
                rom_enable <= 1'b0;
            end
            if (capture) begin
                if (req_id == REQ_DBG) begin
                    dbg_rvalid <= 1'b1;
                    dbg_rdata  <= hit_q ? rom_data : 8'h00;
                end else begin
                    cpu_rvalid <= 1'b1;
                    cpu_rdata  <= hit_q ? rom_data : 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_reflet_boot_rom_ctrl.sv
// Directed bench for reflet_boot_rom_ctrl with a behavioural synchronous ROM.
module tb_reflet_boot_rom_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        dbg_req = 1'b0;
    logic [15:0] dbg_addr = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [7:0]  dbg_rdata;
    logic        boot_exit = 1'b0;
    logic        boot_active;
    logic [14:0] rom_addr;
    logic        rom_enable;
    logic [7:0]  rom_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reflet_boot_rom_ctrl #(.ROM_BASE(16'h7E00), .ROM_SIZE(512)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .boot_exit   (boot_exit),
        .boot_active (boot_active),
        .rom_addr    (rom_addr),
        .rom_enable  (rom_enable),
        .rom_data    (rom_data)
    );

    // Synchronous ROM: registers the address while enabled, output gated by enable.
    logic [7:0] rom_mem [512];
    logic [8:0] rom_q = '0;
    always @(posedge clk) if (rom_enable) rom_q <= rom_addr[8:0];
    assign rom_data = rom_enable ? rom_mem[rom_q] : 8'h00;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        boot_exit = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drives one read by a sole requester from c0 and records what it observes:
    // gnt {cpu,dbg} at c0, rom_enable {c2,c1}, rvalid {cpu,dbg} for c3,c2,c1,
    // rom_addr at c1 and the requester's rdata at c3. Returns at the start of c4.
    task automatic run_read(input logic who, input logic [15:0] addr,
                            output logic [1:0] g, output logic [1:0] en,
                            output logic [5:0] rv, output logic [14:0] ra,
                            output logic [7:0] d);
        en = '0;
        rv = '0;
        ra = '0;
        d  = '0;
        if (who) begin
            dbg_req = 1'b1;
            dbg_addr = addr;
        end else begin
            cpu_req = 1'b1;
            cpu_addr = addr;
        end
        @(negedge clk);
        g = {cpu_gnt, dbg_gnt};
        next_cycle();
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) ra = rom_addr;
            if (c <= 2) en = {rom_enable, en[1]};
            rv = {cpu_rvalid, dbg_rvalid, rv[5:2]};
            if (c == 3) d = who ? dbg_rdata : cpu_rdata;
            next_cycle();
        end
    endtask

    task automatic test_reset();
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        cpu_addr = 16'h7E00;
        dbg_addr = 16'h7E00;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_gnt: got %b expected 00", {cpu_gnt, dbg_gnt});
        end
        checks++;
        if ({cpu_rvalid, dbg_rvalid, rom_enable} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {cpu_rvalid, dbg_rvalid, rom_enable});
        end
        checks++;
        if (rom_addr !== 15'h0000) begin
            errors++; $display("FAIL reset_rom_addr: got %h expected 0000", rom_addr);
        end
        checks++;
        if ({cpu_rdata, dbg_rdata} !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0000", {cpu_rdata, dbg_rdata});
        end
        checks++;
        if (boot_active !== 1'b1) begin
            errors++; $display("FAIL reset_boot_active: got %b expected 1", boot_active);
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        logic [1:0] g, en; logic [5:0] rv; logic [14:0] ra; logic [7:0] d;
        run_read(1'b0, 16'h7E00, g, en, rv, ra, d);
        checks++;
        if (g !== 2'b10) begin errors++; $display("FAIL cpu_read_gnt: got %b expected 10", g); end
        checks++;
        if (en !== 2'b11) begin errors++; $display("FAIL cpu_read_rom_enable: got %b expected 11", en); end
        checks++;
        if (rv !== 6'b100000) begin errors++; $display("FAIL cpu_read_rvalid: got %b expected 100000", rv); end
        checks++;
        if (ra !== 15'h7E00) begin errors++; $display("FAIL cpu_read_rom_addr: got %h expected 7e00", ra); end
        checks++;
        if (d !== 8'h10) begin errors++; $display("FAIL cpu_read_data: got %h expected 10", d); end
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'h10}) begin
            errors++; $display("FAIL cpu_read_hold: got rvalid %b data %h expected 0 10", cpu_rvalid, cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g, exp_rv;
        cpu_addr = 16'h7E01;
        dbg_addr = 16'h7E02;
        for (int c = 0; c <= 12; c++) begin
            cpu_req = (c <= 9);
            dbg_req = (c <= 9);
            @(negedge clk);
            exp_g  = {c == 3 || c == 9, c == 0 || c == 6};
            exp_rv = {c == 6 || c == 12, c == 3 || c == 9};
            checks++;
            if ({cpu_gnt, dbg_gnt} !== exp_g) begin
                errors++; $display("FAIL contention_gnt c%0d: got %b expected %b", c, {cpu_gnt, dbg_gnt}, exp_g);
            end
            checks++;
            if ({cpu_rvalid, dbg_rvalid} !== exp_rv) begin
                errors++; $display("FAIL contention_rvalid c%0d: got %b expected %b", c, {cpu_rvalid, dbg_rvalid}, exp_rv);
            end
            if (c == 3 || c == 9) begin
                checks++;
                if (dbg_rdata !== 8'h32) begin
                    errors++; $display("FAIL contention_dbg_data c%0d: got %h expected 32", c, dbg_rdata);
                end
            end
            if (c == 6 || c == 12) begin
                checks++;
                if (cpu_rdata !== 8'h14) begin
                    errors++; $display("FAIL contention_cpu_data c%0d: got %h expected 14", c, cpu_rdata);
                end
            end
            next_cycle();
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    task automatic test_req_drop();
        dbg_req = 1'b1;
        dbg_addr = 16'h7E01;
        cpu_addr = 16'h7E00;
        for (int c = 0; c <= 7; c++) begin
            dbg_req = (c == 0);
            cpu_req = (c == 1 || c == 2);
            @(negedge clk);
            checks++;
            if (cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b0) begin
                errors++; $display("FAIL req_drop_cpu c%0d: got gnt %b rvalid %b expected 0 0", c, cpu_gnt, cpu_rvalid);
            end
            if (c >= 3) begin
                checks++;
                if (dbg_rvalid !== (c == 3) || rom_enable !== 1'b0) begin
                    errors++; $display("FAIL req_drop_bus c%0d: got dbg_rvalid %b rom_enable %b", c, dbg_rvalid, rom_enable);
                end
            end
            next_cycle();
        end
        checks++;
        if (dbg_rdata !== 8'h14) begin errors++; $display("FAIL req_drop_dbg_data: got %h expected 14", dbg_rdata); end
    endtask

    task automatic test_miss();
        logic [1:0] g, en; logic [5:0] rv; logic [14:0] ra; logic [7:0] d;
        run_read(1'b0, 16'h1234, g, en, rv, ra, d);
        checks++;
        if (g !== 2'b10) begin errors++; $display("FAIL miss_gnt: got %b expected 10", g); end
        checks++;
        if (en !== 2'b00) begin errors++; $display("FAIL miss_rom_enable: got %b expected 00", en); end
        checks++;
        if (rv !== 6'b100000) begin errors++; $display("FAIL miss_rvalid: got %b expected 100000", rv); end
        checks++;
        if (ra !== 15'h1234) begin errors++; $display("FAIL miss_rom_addr: got %h expected 1234", ra); end
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL miss_data: got %h expected 00", d); end
    endtask

    task automatic test_window_edges();
        logic [1:0] g, en; logic [5:0] rv; logic [14:0] ra; logic [7:0] d;
        logic [15:0] addrs [4] = '{16'h7DFF, 16'h8000, 16'hFE00, 16'h7FFF};
        logic [14:0] exp_ra [4] = '{15'h7DFF, 15'h0000, 15'h7E00, 15'h7FFF};
        logic [1:0]  exp_en [4] = '{2'b00, 2'b00, 2'b00, 2'b11};
        logic [7:0]  exp_d  [4] = '{8'h00, 8'h00, 8'h00, 8'hA5};
        for (int k = 0; k < 4; k++) begin
            run_read(1'b0, addrs[k], g, en, rv, ra, d);
            checks++;
            if (en !== exp_en[k] || rv !== 6'b100000) begin
                errors++; $display("FAIL edge_%h_enable: got en %b rv %b expected %b 100000", addrs[k], en, rv, exp_en[k]);
            end
            checks++;
            if (ra !== exp_ra[k]) begin
                errors++; $display("FAIL edge_%h_rom_addr: got %h expected %h", addrs[k], ra, exp_ra[k]);
            end
            checks++;
            if (d !== exp_d[k]) begin
                errors++; $display("FAIL edge_%h_data: got %h expected %h", addrs[k], d, exp_d[k]);
            end
        end
    endtask

    task automatic test_boot_exit();
        logic [1:0] g, en; logic [5:0] rv; logic [14:0] ra; logic [7:0] d;
        boot_exit = 1'b1;
        @(negedge clk);
        checks++;
        if (boot_active !== 1'b1) begin errors++; $display("FAIL boot_exit_same_cycle: got %b expected 1", boot_active); end
        next_cycle();
        boot_exit = 1'b0;
        @(negedge clk);
        checks++;
        if (boot_active !== 1'b0) begin errors++; $display("FAIL boot_exit_cleared: got %b expected 0", boot_active); end
        next_cycle();
        run_read(1'b0, 16'h7E00, g, en, rv, ra, d);
        checks++;
        if (en !== 2'b00) begin errors++; $display("FAIL boot_exit_cpu_enable: got %b expected 00", en); end
        checks++;
        if (rv !== 6'b100000 || d !== 8'h00) begin
            errors++; $display("FAIL boot_exit_cpu_data: got rv %b data %h expected 100000 00", rv, d);
        end
        run_read(1'b1, 16'h7E00, g, en, rv, ra, d);
        checks++;
        if (g !== 2'b01 || en !== 2'b11) begin
            errors++; $display("FAIL boot_exit_dbg_enable: got gnt %b en %b expected 01 11", g, en);
        end
        checks++;
        if (rv !== 6'b010000 || d !== 8'h10) begin
            errors++; $display("FAIL boot_exit_dbg_data: got rv %b data %h expected 010000 10", rv, d);
        end
        checks++;
        if (boot_active !== 1'b0) begin errors++; $display("FAIL boot_exit_sticky: got %b expected 0", boot_active); end
    endtask

    task automatic test_boot_exit_inflight();
        logic [1:0] g, en; logic [5:0] rv; logic [14:0] ra; logic [7:0] d;
        do_reset();
        cpu_req = 1'b1;
        cpu_addr = 16'h7E03;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || boot_active !== 1'b1) begin
            errors++; $display("FAIL inflight_gnt: got gnt %b boot_active %b expected 1 1", cpu_gnt, boot_active);
        end
        next_cycle();
        cpu_req = 1'b0;
        boot_exit = 1'b1;
        @(negedge clk);
        checks++;
        if (rom_enable !== 1'b1) begin errors++; $display("FAIL inflight_addr_enable: got %b expected 1", rom_enable); end
        next_cycle();
        boot_exit = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_enable !== 1'b1 || boot_active !== 1'b0) begin
            errors++; $display("FAIL inflight_data_cycle: got en %b boot_active %b expected 1 0", rom_enable, boot_active);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h31) begin
            errors++; $display("FAIL inflight_result: got rvalid %b data %h expected 1 31", cpu_rvalid, cpu_rdata);
        end
        next_cycle();
        run_read(1'b0, 16'h7E03, g, en, rv, ra, d);
        checks++;
        if (en !== 2'b00 || rv !== 6'b100000 || d !== 8'h00) begin
            errors++; $display("FAIL inflight_next_read: got en %b rv %b data %h expected 00 100000 00", en, rv, d);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g, en; logic [5:0] rv; logic [14:0] ra; logic [7:0] d;
        run_read(1'b1, 16'h7E01, g, en, rv, ra, d);
        checks++;
        if (d !== 8'h14) begin errors++; $display("FAIL reset_mid_pre_read: got %h expected 14", d); end
        dbg_req = 1'b1;
        dbg_addr = 16'h7E02;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL reset_mid_gnt: got %b expected 1", dbg_gnt); end
        next_cycle();
        dbg_req = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (rom_enable !== 1'b1) begin errors++; $display("FAIL reset_mid_data_enable: got %b expected 1", rom_enable); end
        #1;
        reset = 1'b1;
        cpu_req = 1'b1;
        cpu_addr = 16'h7E00;
        #1;
        checks++;
        if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, rom_enable} !== 5'b00000) begin
            errors++; $display("FAIL reset_mid_flags: got %b expected 00000", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, rom_enable});
        end
        checks++;
        if (rom_addr !== 15'h0000 || dbg_rdata !== 8'h00) begin
            errors++; $display("FAIL reset_mid_regs: got rom_addr %h dbg_rdata %h expected 0000 00", rom_addr, dbg_rdata);
        end
        checks++;
        if (boot_active !== 1'b1) begin errors++; $display("FAIL reset_mid_boot_active: got %b expected 1", boot_active); end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_mid_no_rvalid c%0d: got %b expected 0", c, dbg_rvalid); end
            checks++;
            if ({cpu_gnt, rom_enable, cpu_rvalid} !== {c == 0, c == 1 || c == 2, c == 3}) begin
                errors++; $display("FAIL reset_mid_fresh c%0d: got gnt/en/rvalid %b", c, {cpu_gnt, rom_enable, cpu_rvalid});
            end
            if (c == 3) begin
                checks++;
                if (cpu_rdata !== 8'h10) begin errors++; $display("FAIL reset_mid_fresh_data: got %h expected 10", cpu_rdata); end
            end
            next_cycle();
            cpu_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 512; i++) rom_mem[i] = 8'(i) ^ 8'h5A;
        rom_mem[0] = 8'h10;
        rom_mem[1] = 8'h14;
        rom_mem[2] = 8'h32;
        rom_mem[3] = 8'h31;
        reset = 1'b1;
        test_reset();
        test_cpu_read();
        do_reset();
        test_contention();
        test_req_drop();
        test_miss();
        test_window_edges();
        test_boot_exit();
        test_boot_exit_inflight();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reflet_boot_rom_ctrl.md
# reflet_boot_rom_ctrl

Sequencer and arbiter for the 512-byte bootloader ROM at 0x7E00. Shares the ROM's single synchronous read port between the CPU fetch/load path and the debug/loader port. Drives the ROM address and enable with the required one-cycle read latency and gated-output timing. Tracks the boot phase: once software signals boot exit, CPU accesses stop hitting the ROM, so RAM can overlay the window.

## Interface
Parameters:
- `ROM_BASE`, 16'h7E00: first byte address of the ROM window.
- `ROM_SIZE`, 512: window size in bytes; power of two; `ROM_BASE` is aligned to it.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `cpu_req`  in  1: CPU read request; held until granted.
- `cpu_addr`  in  16: CPU byte address; stable while `cpu_req` is high.
- `cpu_gnt`  out  1: combinational; the request is accepted this cycle.
- `cpu_rvalid`  out  1: one-cycle pulse; `cpu_rdata` is valid.
- `cpu_rdata`  out  8: read data; holds its value until the next CPU response.
- `dbg_req`, `dbg_addr`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same widths and rules as the `cpu_*` ports.
- `boot_exit`  in  1: one-cycle pulse from the system register; ends the boot phase.
- `boot_active`  out  1: high from reset until the cycle after `boot_exit` is sampled.
- `rom_addr`  out  15: ROM address, registered.
- `rom_enable`  out  1: ROM enable, registered. The ROM gates its output with this signal.
- `rom_data`  in  8: ROM data, valid while `rom_enable` is high, one cycle after the address.

## Operation
- FSM states: IDLE, ADDR, DATA.
  - IDLE: arbitrate. On a grant, latch the requester ID, `rom_addr <= addr[14:0]` and the hit flag, then go to ADDR.
  - ADDR: ROM registers the address at the end of the cycle; go to DATA.
  - DATA: capture `rom_data` (or 8'h00 on a miss) into the granted port's `rdata`; set its `rvalid` for the next cycle; go to IDLE.
- Grants happen only in IDLE. At most one `gnt` is high per cycle. A requester is never granted twice without an intervening response.
- Arbitration is two-way round-robin:
  - Pointer resets to "CPU last served", so DBG wins the first tie. Decided: the CPU starts after any pending debugger halt request.
  - A sole requester always wins.
  - The pointer updates only on grant.
- Hit condition: `addr[15:log2(ROM_SIZE)] == ROM_BASE[15:log2(ROM_SIZE)]`, and either the requester is DBG or `boot_active` is 1.
- Miss: same FSM path and latency, `rom_enable` stays 0, `rdata` = 8'h00.
- `rom_enable` = 1 in ADDR and DATA on a hit, 0 otherwise. The ROM output is therefore never driven on a miss or while idle.
- `boot_exit` is sticky: `boot_active` clears and stays 0 until reset.
  - A `boot_exit` pulse during an in-flight CPU access does not affect that access; the hit flag was latched at grant.
- Reset values: FSM IDLE; `rom_addr` 0; `rom_enable` 0; both `gnt` 0; both `rvalid` 0; both `rdata` 8'h00; `boot_active` 1; pointer = CPU.
- Reset mid-transaction: the access is dropped and no `rvalid` is issued.

## Timing
- Cycle 0: `req` high in IDLE, `gnt` = 1.
- Cycle 1: ADDR.
- Cycle 2: DATA, `rom_enable` high on a hit.
- Cycle 3: `rvalid` = 1, FSM back in IDLE, and a new grant may be issued in the same cycle.
- Fixed latency is 3 cycles from `gnt` to `rvalid`. Throughput is one access per 3 cycles.
- Both requesters contending continuously get alternating grants at cycles 0, 3, 6, …
- A `req` that drops before `gnt` is not served. Requesters must not do this; the bench checks that no access is issued.

## Structure
- Package `reflet_boot_rom_pkg`:
  - FSM state enum (IDLE/ADDR/DATA).
  - Requester ID constants (CPU=0, DBG=1).
  - Default `ROM_BASE`/`ROM_SIZE`.
  - Address-width constants (16 bus, 15 ROM).
- One sub-module, `reflet_rr_arb2`: two requests, grant vector, pointer register with the reset state above.
- The ROM itself is instantiated outside this block, at the microcontroller level.

## Test plan
- CPU reads 0x7E00 after reset: `cpu_gnt` at c0, `rom_enable` high c1–c2, `cpu_rvalid` at c3 with `cpu_rdata` = 8'h10. `dbg_rvalid` stays 0.
- CPU and DBG both request from c0, addresses 0x7E01 and 0x7E02:
  - DBG is granted at c0 and gets 8'h32 at c3.
  - CPU is granted at c3 and gets 8'h14 at c6.
  - The grant order alternates thereafter.
- CPU reads 0x1234: `rom_enable` stays 0, `cpu_rvalid` at c3 with data 8'h00.
- Pulse `boot_exit`, then have CPU read 0x7E00 and DBG read 0x7E00:
  - `boot_active` = 0.
  - CPU gets 8'h00 with no `rom_enable`.
  - DBG gets 8'h10.
- Pulse `boot_exit` during the ADDR cycle of a CPU read of 0x7E03: that read still returns 8'h31. The next CPU read of 0x7E03 returns 8'h00.
- Assert `reset` in the DATA cycle:
  - All outputs return to their reset values immediately.
  - No `rvalid` is issued.
  - `boot_active` = 1.
  - A fresh read after release completes normally.
